lfsr_rng_sched: RTL
===================

// Module: lfsr_rng_sched
// PURPOSE
//  Owns one 16-bit Fibonacci LFSR and shares its output among NREQ requesters.
//  Grants are round-robin; the block sequences seeding, warm-up and inter-grant advance.
//  Sits between the random-number consumers (test-pattern gens, scramblers) and the LFSR datapath.
//  LFSR step: q <= {q[14:0], q[15]^q[13]^q[12]^q[10]}; reset/default state 16'hFFFF.
// PARAMETERS
//  NREQ          4   number of requesters, 2..8
//  WARMUP_STEPS  16  LFSR steps run after reset/seed before first grant, 1..255
//  ADV_STEPS     3   LFSR steps between consecutive grants, 1..15
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous, active-low reset
//  seed_load  in   1     pulse: load seed_in into LFSR, restart warm-up
//  seed_in    in   16    seed value; 16'h0000 replaced by 16'hFFFF
//  req        in   NREQ  level request per requester; held until granted
//  gnt        out  NREQ  one-hot, 1-cycle grant; rnd_data valid same cycle
//  rnd_data   out  16    LFSR word delivered with gnt
//  busy       out  1     high in WARMUP/ADVANCE (no grant possible)
// BEHAVIOUR
//  Reset (rst=0, async): lfsr=16'hFFFF, state=WARMUP, cnt=WARMUP_STEPS, rr_ptr=0,
//   gnt=0, rnd_data=0, busy=1.
//  States: WARMUP, SERVE, ADVANCE. LFSR steps once per cycle in WARMUP and ADVANCE only.
//  WARMUP: step, cnt--; when cnt reaches 1 -> SERVE next cycle (exactly WARMUP_STEPS steps).
//  SERVE: LFSR holds. If any req: grant lowest index i >= rr_ptr (circular);
//   registered: gnt[i]=1 and rnd_data=current lfsr for one cycle; rr_ptr=(i+1)%NREQ;
//   cnt=ADV_STEPS, -> ADVANCE. No req: stay, gnt=0, rr_ptr unchanged.
//  Latency: req seen in SERVE at edge N -> gnt high after edge N+1 (one registered stage).
//  ADVANCE: step, cnt--; after ADV_STEPS steps -> SERVE. Max grant rate 1 per ADV_STEPS+1 cycles.
//  gnt is never high outside the cycle following a SERVE decision; never more than one bit set.
//  rnd_data holds the last delivered value between grants (not cleared).
//  seed_load has priority over everything, in any state: lfsr=(seed_in==0)?16'hFFFF:seed_in,
//   cnt=WARMUP_STEPS, -> WARMUP, gnt=0 that cycle (a grant decision in the same cycle is dropped),
//   rr_ptr preserved.
//  Lockup guard: if lfsr ever equals 16'h0000 it is forced to 16'hFFFF on the next step.
//  req deasserted before grant: no grant, no error. req bits >= NREQ do not exist.
//  busy = (state != SERVE), combinational from state register.
// CONFIGURATION
//  LFSR_GRANT_CNT_EN defined: extra port grant_cnt out 16 = number of grants since
//   reset/seed_load; increments with each gnt pulse, wraps 16'hFFFF->0, cleared to 0 on
//   rst and seed_load.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package lfsr_pkg: LFSR_W=16, LFSR_RESET=16'hFFFF, tap mask 16'hB400, state enum
//   {ST_WARMUP, ST_SERVE, ST_ADVANCE}.
//  Sub-module lfsr_core (lfsr register + step/load/zero-guard, enable input);
//   arbiter and FSM stay in lfsr_rng_sched.
// TESTING
//  1 Reset, WARMUP_STEPS=1, req=0: first step FFFF->FFFE; busy 1->0 after 1 step; gnt stays 0.
//  2 seed_load seed_in=16'h0001, WARMUP_STEPS=1, req=4'b0001: lfsr=0x0002, gnt=4'b0001,
//   rnd_data=16'h0002.
//  3 req=4'b1111 held: grants 0,1,2,3,0 in order, spaced ADV_STEPS+1=4 cycles; rnd_data matches
//   golden LFSR model.
//  4 seed_in=16'h0000 -> LFSR loads 16'hFFFF; sequence equals post-reset sequence.
//  5 seed_load asserted in the SERVE cycle with req=4'b0100: no gnt, busy=1, WARMUP restarts,
//   rr_ptr unchanged.
//  6 LFSR_GRANT_CNT_EN: 5 grants -> grant_cnt=5; seed_load -> 0; preset 16'hFFFF + 1 grant -> 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR random-number scheduler.
// Also holds the single-step function of the 16-bit Fibonacci LFSR.
package lfsr_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 16'hFFFF;
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_SERVE   = 2'd1,
    ST_ADVANCE = 2'd2
  } state_e;

  // An all-zero register would lock up, so it is pushed back to the reset state
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    logic [LFSR_W-1:0] n;
    if (q == 16'h0000) begin
      n = LFSR_RESET;
    end else begin
      n = {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// 16-bit Fibonacci LFSR register with seed load (priority) and step enable.
module lfsr_core
  import lfsr_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_q
);

  logic [LFSR_W-1:0] r_q;

  // LFSR state: load beats step; a zero seed is replaced by the reset value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= LFSR_RESET;
    end else if (i_load) begin
      r_q <= (i_seed == 16'h0000) ? LFSR_RESET : i_seed;
    end else if (i_step) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/lfsr_rng_sched.sv
// Round-robin scheduler sharing one LFSR among NREQ requesters (warm-up, serve, advance).
// Optional grant counter port enabled by defining LFSR_GRANT_CNT_EN.
module lfsr_rng_sched
  import lfsr_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int WARMUP_STEPS = 16,
  parameter int ADV_STEPS    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [LFSR_W-1:0] rnd_data,
  output logic              busy
`ifdef LFSR_GRANT_CNT_EN
  ,
  output logic [15:0]       grant_cnt
`endif
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = 8;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [NREQ-1:0]   r_gnt;
  logic [LFSR_W-1:0] r_rnd_data;

  logic [LFSR_W-1:0] w_lfsr;
  logic              w_step;
  logic              w_any_req;
  logic [PTR_W-1:0]  w_pick;
  logic [PTR_W:0]    w_sum;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W-1:0]  w_ptr_next;
  logic [NREQ-1:0]   w_gnt_onehot;

  assign w_step = (r_state != ST_SERVE);

  lfsr_core u_lfsr_core (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (seed_load),
    .i_seed  (seed_in),
    .i_step  (w_step),
    .o_q     (w_lfsr)
  );

  // Scan from the highest circular offset down so the first requester at/after rr_ptr wins
  always_comb begin
    w_any_req = 1'b0;
    w_pick    = r_rr_ptr;
    w_sum     = {(PTR_W+1){1'b0}};
    w_idx     = {PTR_W{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum     = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      w_idx     = (w_sum >= (PTR_W+1)'(NREQ)) ? PTR_W'(w_sum - (PTR_W+1)'(NREQ)) : PTR_W'(w_sum);
      w_pick    = req[w_idx] ? w_idx : w_pick;
      w_any_req = w_any_req | req[w_idx];
    end
  end

  assign w_ptr_next   = (w_pick == PTR_W'(NREQ - 1)) ? {PTR_W{1'b0}} : (w_pick + PTR_W'(1));
  assign w_gnt_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;

  // Sequencer: seed_load overrides everything, including a grant decided in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_WARMUP;
      r_cnt      <= CNT_W'(WARMUP_STEPS);
      r_rr_ptr   <= {PTR_W{1'b0}};
      r_gnt      <= {NREQ{1'b0}};
      r_rnd_data <= {LFSR_W{1'b0}};
    end else if (seed_load) begin
      r_state <= ST_WARMUP;
      r_cnt   <= CNT_W'(WARMUP_STEPS);
      r_gnt   <= {NREQ{1'b0}};
    end else begin
      case (r_state)
        ST_WARMUP, ST_ADVANCE: begin
          r_gnt <= {NREQ{1'b0}};
          if (r_cnt <= 8'd1) begin
            r_state <= ST_SERVE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_SERVE: begin
          if (w_any_req) begin
            r_gnt      <= w_gnt_onehot;
            r_rnd_data <= w_lfsr;
            r_rr_ptr   <= w_ptr_next;
            r_cnt      <= CNT_W'(ADV_STEPS);
            r_state    <= ST_ADVANCE;
          end else begin
            r_gnt <= {NREQ{1'b0}};
          end
        end
        default: begin
          r_state <= ST_WARMUP;
          r_cnt   <= CNT_W'(WARMUP_STEPS);
          r_gnt   <= {NREQ{1'b0}};
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign rnd_data = r_rnd_data;
  assign busy     = (r_state != ST_SERVE);

`ifdef LFSR_GRANT_CNT_EN
  logic [15:0] r_grant_cnt;

  // Counts grant decisions so the count moves together with the gnt pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant_cnt <= 16'h0000;
    end else if (seed_load) begin
      r_grant_cnt <= 16'h0000;
    end else if ((r_state == ST_SERVE) && w_any_req) begin
      r_grant_cnt <= r_grant_cnt + 16'h0001;
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule
